// File: rtl/ifetch_pfq.sv
// rtl/ifetch_pfq.sv - instruction fetch unit with a DEPTH-entry prefetch queue
module ifetch_pfq #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              req_o,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

  logic [INST_W-1:0] qinst_q [DEPTH];
  logic [ADDR_W-1:0] qaddr_q [DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occupancy;

  // Head presentation, pop/push decisions and fetch request for this cycle.
  // The response arriving in a branch cycle belongs to the old stream and is
  // not written; the fetch issued in that cycle is the target itself.
  always_comb begin
    valid_o     = ~rst & (count_q != '0);
    inst_o      = valid_o ? qinst_q[rd_ptr_q] : '0;
    pc_o        = valid_o ? qaddr_q[rd_ptr_q] : '0;
    pop         = valid_o & ~stall_i & ~branch_i;
    push        = ~rst & inflight_q & ~branch_i;
    occupancy   = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue       = ~rst & (occupancy < (CNT_W+1)'(DEPTH));
    if (rst) begin
      inst_addr_o = ADDR_W'(RST_PC);
      req_o       = 1'b0;
    end else if (branch_i) begin
      inst_addr_o = branch_addr_i;
      req_o       = 1'b1;
    end else begin
      inst_addr_o = pc_q;
      req_o       = issue;
    end
  end

  // Next-state for fetch address, queue pointers, occupancy and in-flight tracking.
  always_comb begin
    pc_d            = pc_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    inflight_d      = req_o;
    inflight_addr_d = inst_addr_o;
    if (branch_i) begin
      pc_d     = branch_addr_i + ADDR_W'(1);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers with synchronous reset; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= ADDR_W'(RST_PC);
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  // Queue storage: capture the returned instruction with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      qinst_q[wr_ptr_q] <= inst_i;
      qaddr_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

endmodule

// File: tb/tb_ifetch_pfq.sv
// tb/tb_ifetch_pfq.sv - self-checking bench for ifetch_pfq against a queue-level model
module tb_ifetch_pfq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_i = '0;
  logic [15:0] inst_addr_o;
  logic        req_o;
  logic        branch_i = 1'b0;
  logic [15:0] branch_addr_i = '0;
  logic        stall_i = 1'b0;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [15:0] pc_o;

  int checks = 0;
  int errors = 0;

  ifetch_pfq #(.ADDR_W(16), .INST_W(32), .DEPTH(4), .RST_PC(0)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_o(inst_addr_o), .req_o(req_o),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i), .stall_i(stall_i),
    .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0, a};
  endfunction

  // synchronous-read instruction memory, one cycle latency
  always @(posedge clk) inst_i <= memf(inst_addr_o);

  // reference model: pending instruction addresses in order, plus one outstanding read
  logic [15:0] mq[$];
  bit          m_infl = 0;
  logic [15:0] m_infl_addr = '0;
  logic [15:0] m_pc = '0;

  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc;
  logic [31:0] s_inst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit b, input logic [15:0] ba, input bit s);
    bit          e_req, e_valid, pop;
    logic [15:0] e_addr, e_pc;
    logic [31:0] e_inst;
    int          occ;
    @(negedge clk);
    rst = r; branch_i = b; branch_addr_i = ba; stall_i = s;
    #1;
    pop = 0;
    if (r) begin
      e_req = 0; e_valid = 0; e_addr = 16'h0000; e_pc = '0; e_inst = '0;
    end else begin
      e_valid = (mq.size() != 0);
      e_pc    = e_valid ? mq[0] : 16'h0;
      e_inst  = e_valid ? memf(mq[0]) : 32'h0;
      pop     = e_valid && !s && !b;
      if (b) begin
        e_req = 1; e_addr = ba;
      end else begin
        occ    = mq.size() - int'(pop) + int'(m_infl);
        e_req  = (occ < 4);
        e_addr = m_pc;
      end
    end
    chk("req_o", req_o, e_req);
    chk("inst_addr_o", inst_addr_o, e_addr);
    chk("valid_o", valid_o, e_valid);
    chk("pc_o", pc_o, e_pc);
    chk("inst_o", inst_o, e_inst);
    s_req = req_o; s_addr = inst_addr_o; s_valid = valid_o; s_pc = pc_o; s_inst = inst_o;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_pc   = 16'h0000;
      m_infl = 0;
    end else begin
      if (b) begin
        mq.delete();
        m_pc = ba + 16'd1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_addr);
        if (e_req) m_pc = m_pc + 16'd1;
      end
      m_infl      = e_req;
      m_infl_addr = e_addr;
    end
  endtask

  initial begin
    logic [15:0] last_fetch;
    logic [15:0] wrap_exp [4];
    bit          r, b, s;
    logic [15:0] ba;
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

    // reset release
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rel_c0_req", s_req, 1);
    chk("rel_c0_addr", s_addr, 16'h0000);
    step(0, 0, 0, 0);
    chk("rel_c1_valid", s_valid, 0);
    step(0, 0, 0, 0);
    chk("rel_c2_valid", s_valid, 1);
    chk("rel_c2_pc", s_pc, 16'h0000);
    chk("rel_c2_inst", s_inst, 32'h1000_0000);
    step(0, 0, 0, 0);
    chk("rel_c3_pc", s_pc, 16'h0001);

    // long stall with pc 2 at the head
    last_fetch = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      chk("stall_head", s_pc, 16'h0002);
      if (s_req) last_fetch = s_addr;
    end
    chk("stall_last_fetch", last_fetch, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("stall_release_pc", s_pc, 16'(2 + i));
    end

    // branch with a read in flight
    step(0, 1, 16'h0040, 0);
    chk("br_req", s_req, 1);
    chk("br_addr", s_addr, 16'h0040);
    step(0, 0, 0, 0);
    chk("br_n1_valid", s_valid, 0);
    step(0, 0, 0, 0);
    chk("br_n2_pc", s_pc, 16'h0040);
    chk("br_n2_inst", s_inst, 32'h1000_0040);
    step(0, 0, 0, 0);
    chk("br_n3_pc", s_pc, 16'h0041);

    // branch while stalled with a full queue
    repeat (6) step(0, 0, 0, 1);
    step(0, 1, 16'h0100, 1);
    step(0, 0, 0, 1);
    chk("brst_n1_valid", s_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("brst_hold_pc", s_pc, 16'h0100);
      chk("brst_hold_valid", s_valid, 1);
    end

    // address wrap
    step(0, 1, 16'hFFFE, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("wrap_pc", s_pc, wrap_exp[i]);
    end

    // reset mid-stream with three queued and one in flight
    repeat (2) step(0, 0, 0, 1);
    chk("mid_queue_depth", mq.size(), 3);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("mid_valid", s_valid, 0);
    chk("mid_restart_addr", s_addr, 16'h0000);
    step(0, 0, 0, 0);
    chk("mid_n2_valid", s_valid, 0);
    step(0, 0, 0, 0);
    chk("mid_head_pc", s_pc, 16'h0000);
    chk("mid_head_inst", s_inst, 32'h1000_0000);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) == 0);
      b  = ($urandom_range(99) < 6);
      s  = ($urandom_range(99) < 35);
      ba = ($urandom_range(7) == 0) ? 16'(16'hFFFC + $urandom_range(3)) : 16'($urandom);
      step(r, b, ba, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
